// File: rtl/delivery_collision_score_if.sv
// Game-logic bus between the map/player front end and the collision/score block.
// master drives the map rows and player controls; slave returns lives, score and events.
interface delivery_collision_score_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               move_map;
  logic [1:0]         player_lane;
  logic [63:0]        map_obstacles_flat;
  logic [63:0]        map_objectives_flat;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               hit;
  logic               collect;
  logic               playing;
  logic               invuln;
  logic               game_over;

  modport master (
    output start, move_map, player_lane, map_obstacles_flat, map_objectives_flat,
    input  lives, score, hit, collect, playing, invuln, game_over
  );

  modport slave (
    input  start, move_map, player_lane, map_obstacles_flat, map_objectives_flat,
    output lives, score, hit, collect, playing, invuln, game_over
  );
endinterface

// File: rtl/delivery_collision_score.sv
// Row-0 collision/collect detection, lives/score counters and game-phase FSM
// for the delivery game; one hit or collect event per map row at most.
module delivery_collision_lane (
  input  logic sel,
  input  logic obs,
  input  logic obj,
  output logic obs_hit,
  output logic obj_hit
);
  assign obs_hit = sel & obs;
  assign obj_hit = sel & obj;
endmodule

module delivery_collision_score #(
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_W      = 8,
  parameter int INVULN_STEPS = 4
) (
  input logic clock,
  input logic reset,
  delivery_collision_score_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_INVULN, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic [3:0]         cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               collect_q, collect_d;
  logic               row_used_q, row_used_d;
  logic               step_dly_q, step_dly_d;
  logic               playing_q, playing_d;
  logic               invuln_q, invuln_d;
  logic               game_over_q, game_over_d;

  logic [NUM_LANES-1:0] lane_oh, obs_lane, obj_lane;
  logic                 obs0, obj0, check;

  assign lane_oh = NUM_LANES'(1) << bus.player_lane;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    delivery_collision_lane u_lane (
      .sel     (lane_oh[g]),
      .obs     (bus.map_obstacles_flat[g]),
      .obj     (bus.map_objectives_flat[g]),
      .obs_hit (obs_lane[g]),
      .obj_hit (obj_lane[g])
    );
  end

  // Rows 1..15 are never inspected here.
  logic unused_rows;
  assign unused_rows = ^{bus.map_obstacles_flat[63:NUM_LANES], bus.map_objectives_flat[63:NUM_LANES]};

  assign obs0      = |obs_lane;
  assign obj0      = |obj_lane;
  assign check     = !row_used_q || step_dly_q;
  assign score_inc = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    hit_d      = 1'b0;
    collect_d  = 1'b0;
    row_used_d = step_dly_q ? 1'b0 : row_used_q;
    step_dly_d = bus.move_map;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d    = S_PLAYING;
          lives_d    = 2'(LIVES_INIT);
          score_d    = '0;
          cnt_d      = '0;
          // The row on screen at start is never scored.
          row_used_d = 1'b1;
        end
      end
      S_PLAYING: begin
        if (check && obs0) begin
          hit_d      = 1'b1;
          lives_d    = lives_q - 2'd1;
          row_used_d = 1'b1;
          if (lives_q == 2'd1) begin
            state_d = S_OVER;
          end else begin
            state_d = S_INVULN;
            cnt_d   = 4'(INVULN_STEPS);
          end
        end else if (check && obj0) begin
          collect_d  = 1'b1;
          score_d    = score_inc;
          row_used_d = 1'b1;
        end
      end
      S_INVULN: begin
        if (check && obj0) begin
          collect_d  = 1'b1;
          score_d    = score_inc;
          row_used_d = 1'b1;
        end
        if (bus.move_map) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_PLAYING;
        end
      end
      default: state_d = S_IDLE;
    endcase

    playing_d   = (state_d == S_PLAYING) || (state_d == S_INVULN);
    invuln_d    = (state_d == S_INVULN);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      collect_q   <= 1'b0;
      row_used_q  <= 1'b0;
      step_dly_q  <= 1'b0;
      playing_q   <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      collect_q   <= collect_d;
      row_used_q  <= row_used_d;
      step_dly_q  <= step_dly_d;
      playing_q   <= playing_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.hit       = hit_q;
  assign bus.collect   = collect_q;
  assign bus.playing   = playing_q;
  assign bus.invuln    = invuln_q;
  assign bus.game_over = game_over_q;
endmodule
